// File: rtl/byte_packer.sv
// byte_packer: packs a byte stream into 32-bit words for a string comparator.
// Optional PACKER_PAD_SPACE_EN pads short final words with 8'h20 instead of 8'h00.
module byte_packer #(
    parameter int FLUSH_WORDS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic        ready,
    output logic [31:0] data_out,
    output logic        word_valid,
    output logic        clear,
    output logic [10:0] byte_count
);

`ifdef PACKER_PAD_SPACE_EN
    localparam logic [7:0] PAD = 8'h20;
`else
    localparam logic [7:0] PAD = 8'h00;
`endif

    localparam int FCW = (FLUSH_WORDS > 1) ? $clog2(FLUSH_WORDS) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_WORDS - 1);
    localparam logic [10:0] COUNT_MAX = 11'd2047;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        FLUSH = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t          state_q;
    logic [1:0]      lane_q;
    logic [23:0]     part_q;
    logic [31:0]     data_out_q;
    logic            word_valid_q;
    logic            clear_q;
    logic [10:0]     byte_count_q;
    logic [FCW-1:0]  flush_cnt_q;

    logic            ready_d;
    logic            accept_d;
    logic            emit_d;
    logic [31:0]     packed_d;

    assign ready_d  = (state_q == IDLE) || (state_q == PACK);
    assign accept_d = byte_valid && ready_d;
    assign emit_d   = byte_last || (lane_q == 2'd3);

    // Lanes not yet written are filled with PAD so a short last word is ready as-is.
    always_comb begin
        packed_d = '0;
        case (lane_q)
            2'd0: packed_d = {byte_in, PAD, PAD, PAD};
            2'd1: packed_d = {part_q[23:16], byte_in, PAD, PAD};
            2'd2: packed_d = {part_q[23:8], byte_in, PAD};
            2'd3: packed_d = {part_q[23:0], byte_in};
            default: packed_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lane_q       <= 2'd0;
            part_q       <= '0;
            data_out_q   <= '0;
            word_valid_q <= 1'b0;
            clear_q      <= 1'b0;
            byte_count_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            data_out_q   <= '0;
            word_valid_q <= 1'b0;
            clear_q      <= 1'b0;
            case (state_q)
                IDLE, PACK: begin
                    if (accept_d) begin
                        if (state_q == IDLE)
                            byte_count_q <= 11'd1;
                        else if (byte_count_q != COUNT_MAX)
                            byte_count_q <= byte_count_q + 11'd1;
                        if (emit_d) begin
                            data_out_q   <= packed_d;
                            word_valid_q <= 1'b1;
                            part_q       <= '0;
                        end else begin
                            part_q <= packed_d[31:8];
                        end
                        lane_q      <= byte_last ? 2'd0 : lane_q + 2'd1;
                        state_q     <= byte_last ? FLUSH : PACK;
                        flush_cnt_q <= '0;
                    end
                end
                FLUSH: begin
                    // The cycle showing the final word is not a drain cycle.
                    if (!word_valid_q) begin
                        if (flush_cnt_q == FLUSH_LAST) begin
                            state_q <= CLEAR;
                            clear_q <= 1'b1;
                        end else begin
                            flush_cnt_q <= flush_cnt_q + FCW'(1);
                        end
                    end
                end
                CLEAR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready      = ready_d;
    assign data_out   = data_out_q;
    assign word_valid = word_valid_q;
    assign clear      = clear_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_byte_packer.sv
// Directed testbench for byte_packer.
// Pad expectations follow PACKER_PAD_SPACE_EN like the design.
module tb_byte_packer;

    localparam int FW = 5;

`ifdef PACKER_PAD_SPACE_EN
    localparam logic [31:0] WWW_W3 = 32'h6F6D2020;
    localparam logic [31:0] A_W    = 32'h61202020;
`else
    localparam logic [31:0] WWW_W3 = 32'h6F6D0000;
    localparam logic [31:0] A_W    = 32'h61000000;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;
    logic        ready;
    logic [31:0] data_out;
    logic        word_valid;
    logic        clear;
    logic [10:0] byte_count;

    int n_vec;
    int n_err;

    byte_packer #(.FLUSH_WORDS(FW)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .ready      (ready),
        .data_out   (data_out),
        .word_valid (word_valid),
        .clear      (clear),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last,
                        input logic exp_wv, input logic [31:0] exp_w);
        chk("ready_in", {31'b0, ready}, 32'd1);
        byte_in    = b;
        byte_valid = 1'b1;
        byte_last  = last;
        tick();
        chk("wv", {31'b0, word_valid}, {31'b0, exp_wv});
        chk("data", data_out, exp_wv ? exp_w : 32'h0);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    // Expects the cycle showing the last word to have just been sampled.
    task automatic drain(input logic [10:0] cnt);
        for (int k = 0; k < FW; k++) begin
            tick();
            chk("fl_wv", {31'b0, word_valid}, 32'd0);
            chk("fl_data", data_out, 32'h0);
            chk("fl_clear", {31'b0, clear}, 32'd0);
            chk("fl_ready", {31'b0, ready}, 32'd0);
            chk("fl_count", {21'b0, byte_count}, {21'b0, cnt});
        end
        tick();
        chk("clr_pulse", {31'b0, clear}, 32'd1);
        chk("clr_ready", {31'b0, ready}, 32'd0);
        chk("clr_wv", {31'b0, word_valid}, 32'd0);
    endtask

    task automatic after_clear(input logic [10:0] cnt);
        tick();
        chk("idle_clear", {31'b0, clear}, 32'd0);
        chk("idle_ready", {31'b0, ready}, 32'd1);
        chk("idle_count", {21'b0, byte_count}, {21'b0, cnt});
    endtask

    initial begin
        string       s;
        logic [31:0] www_w [4];
        logic [31:0] ew;
        logic [7:0]  b;
        bit          lastb;
        n_vec = 0;
        n_err = 0;
        www_w[0] = 32'h7777772E;
        www_w[1] = 32'h676F6F67;
        www_w[2] = 32'h6C652E63;
        www_w[3] = WWW_W3;

        rst        = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        tick();
        tick();
        chk("rst_data", data_out, 32'h0);
        chk("rst_wv", {31'b0, word_valid}, 32'd0);
        chk("rst_clear", {31'b0, clear}, 32'd0);
        chk("rst_count", {21'b0, byte_count}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Full packet back to back
        s = "www.google.com";
        for (int i = 0; i < 14; i++) begin
            lastb = (i == 13);
            ew = www_w[i / 4];
            send(s[i], lastb, (i % 4 == 3) || lastb, ew);
            if (i == 0)
                chk("cnt_first", {21'b0, byte_count}, 32'd1);
        end
        chk("www_count", {21'b0, byte_count}, 32'd14);
        drain(11'd14);
        after_clear(11'd14);

        // Single byte packet
        send(8'h61, 1'b1, 1'b1, A_W);
        chk("one_count", {21'b0, byte_count}, 32'd1);
        drain(11'd1);
        after_clear(11'd1);

        // Gapped input
        s = "abcd";
        for (int i = 0; i < 4; i++) begin
            send(s[i], i == 3, i == 3, 32'h61626364);
            if (i != 3) begin
                tick();
                chk("gap_wv", {31'b0, word_valid}, 32'd0);
                chk("gap_data", data_out, 32'h0);
            end
        end
        drain(11'd4);
        after_clear(11'd4);

        // Backpressure through FLUSH and CLEAR
        send(8'h78, 1'b0, 1'b0, 32'h0);
        send(8'h79, 1'b1, 1'b1, 32'h78790000 | (A_W & 32'h0000FFFF));
        byte_in    = 8'h55;
        byte_valid = 1'b1;
        drain(11'd2);
        byte_valid = 1'b0;
        after_clear(11'd2);
        tick();
        chk("bp_wv", {31'b0, word_valid}, 32'd0);

        // Reset mid-packet
        send(8'h61, 1'b0, 1'b0, 32'h0);
        send(8'h62, 1'b0, 1'b0, 32'h0);
        rst        = 1'b1;
        byte_in    = 8'h63;
        byte_valid = 1'b1;
        tick();
        chk("mr_wv", {31'b0, word_valid}, 32'd0);
        chk("mr_clear", {31'b0, clear}, 32'd0);
        chk("mr_count", {21'b0, byte_count}, 32'd0);
        chk("mr_ready", {31'b0, ready}, 32'd1);
        rst        = 1'b0;
        byte_valid = 1'b0;
        for (int k = 0; k < FW + 2; k++) begin
            tick();
            chk("mr_idle_wv", {31'b0, word_valid}, 32'd0);
            chk("mr_idle_clr", {31'b0, clear}, 32'd0);
        end
        s = "wxyz";
        for (int i = 0; i < 4; i++)
            send(s[i], i == 3, i == 3, 32'h7778797A);
        drain(11'd4);
        after_clear(11'd4);

        // Long packet: count saturates, words stay correct
        for (int i = 0; i < 2052; i++) begin
            b  = 8'(i);
            ew = {b - 8'd3, b - 8'd2, b - 8'd1, b};
            send(b, i == 2051, (i % 4) == 3, ew);
        end
        chk("sat_count", {21'b0, byte_count}, 32'd2047);
        drain(11'd2047);
        after_clear(11'd2047);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 Parameter FLUSH_WORDS, default 5: number of idle drain cycles after a packet's last word, enough to flush a 17-byte comparator window.
REQ-002 clk  input  1  single clock; all logic is rising-edge triggered.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 byte_in  input  8  received payload byte.
REQ-005 byte_valid  input  1  byte_in is offered this cycle.
REQ-006 byte_last  input  1  offered byte is the final byte of the packet; ignored unless byte_valid=1.
REQ-007 ready  output  1  packer accepts a byte this cycle; a byte is accepted when byte_valid=1 and ready=1.
REQ-008 data_out  output  32  packed word for the downstream string comparator's data_in.
REQ-009 word_valid  output  1  data_out holds a packed word this cycle.
REQ-010 clear  output  1  one-cycle pulse that resets the downstream comparator between packets.
REQ-011 byte_count  output  11  number of bytes accepted in the current or most recent packet; saturates at 2047.

Function
REQ-012 The packer SHALL have exactly four states: IDLE, PACK, FLUSH and CLEAR.
REQ-013 Lane order SHALL place the first byte of a word in data_out[31:24], then [23:16], [15:8] and [7:0] (string-literal order).
REQ-014 A lane counter SHALL run 0..3, advance on each accepted byte, wrap 3->0 and reset to 0 at packet end.
REQ-015 On the edge that accepts the 4th byte of a word, data_out SHALL take the packed word and word_valid SHALL be 1 for exactly the following cycle (latency 1).
REQ-016 On an accepted byte with byte_last=1 in lane 0..2, unfilled lanes SHALL be padded and the word emitted with the same 1-cycle latency.
REQ-017 When word_valid=0, data_out SHALL be 32'h0.
REQ-018 byte_valid=0 in PACK SHALL hold the partial word unchanged and emit nothing (gaps allowed).
REQ-019 IDLE -> PACK on an accepted byte with byte_last=0.
REQ-020 IDLE -> FLUSH or PACK -> FLUSH on an accepted byte with byte_last=1; a single-byte packet SHALL be legal.
REQ-021 FLUSH SHALL last exactly FLUSH_WORDS cycles with word_valid=0 and data_out=0, then go to CLEAR.
REQ-022 CLEAR SHALL last one cycle with clear=1, then go to IDLE.
REQ-023 ready SHALL be 1 in IDLE and PACK and 0 in FLUSH and CLEAR.
REQ-024 Bytes offered while ready=0 SHALL be ignored: no state, lane or count change.
REQ-025 byte_count SHALL load 1 on the first accepted byte of a packet and increment on each further accepted byte.
REQ-026 byte_count SHALL stick at 2047 without wrapping.
REQ-027 byte_count SHALL hold its value through FLUSH, CLEAR and IDLE until the next packet's first byte.
REQ-028 A packet exceeding 2047 bytes SHALL still pack and emit every word correctly.
REQ-029 The 5th accepted byte of a packet SHALL land in lane 0 of the next word, with no bubble cycle between back-to-back words.

Reset
REQ-030 While rst=1 at a clock edge, the state SHALL go to IDLE and the lane counter and partial word SHALL clear.
REQ-031 During reset, data_out=0, word_valid=0, clear=0, byte_count=0 and ready=1 from the first edge after rst is sampled.
REQ-032 Reset mid-packet, in FLUSH or in CLEAR SHALL discard the packet and SHALL NOT emit a partial word or a clear pulse.
REQ-033 rst SHALL take priority over byte_valid in the same cycle.

Configuration
REQ-034 With PACKER_PAD_SPACE_EN defined, pad bytes SHALL be 8'h20 (ASCII space).
REQ-035 With PACKER_PAD_SPACE_EN undefined, pad bytes SHALL be 8'h00.
REQ-036 PACKER_PAD_SPACE_EN SHALL change no timing or state behaviour.

Verification
REQ-037 Reset check: rst=1 for 2 cycles -> data_out=0, word_valid=0, clear=0, byte_count=0 and ready=1.
REQ-038 Full packet, PACKER_PAD_SPACE_EN defined: "www.google.com" back-to-back, byte_last on 'm' ->
  - words 0x7777772E, 0x676F6F67, 0x6C652E63, 0x6F6D2020 on consecutive word_valid cycles;
  - then 5 cycles of 0 and clear=1 for one cycle;
  - byte_count=14.
REQ-039 Single-byte packet: 'a' (0x61) with byte_last=1 ->
  - word 0x61202020 (0x61000000 without the macro);
  - FLUSH_WORDS cycles later, clear=1 for one cycle.
REQ-040 Gapped input: "abcd" with byte_valid toggling every other cycle -> word_valid stays 0 until the cycle after 'd', then one word 0x61626364.
REQ-041 Backpressure: byte_valid=1 held through FLUSH and CLEAR -> ready=0, byte_count unchanged, no words emitted.
REQ-042 Reset mid-packet: rst after 2 bytes of "abcd" ->
  - no word and no clear pulse;
  - a following "wxyz" packet emits 0x7778797A.
